// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MD_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline stage registers and the hazard controller.
// master = pipeline side (drives register indices/enables), slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
    logic [REG_ADDR_W-1:0] RdE, RdM, RdW;
    logic [1:0]            ResultSrcE;
    logic                  RegWriteM, RegWriteW;
    logic [1:0]            PCSrcE;
    logic                  MulDivStartE, MulDivDoneE;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  StallF, StallD, StallE;
    logic                  FlushD, FlushE, FlushM;
    logic [CNT_W-1:0]      StallCount, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivDoneE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivDoneE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_ctrl_forward_select.sv
// Forwarding mux select for one EX source operand; purely combinational.
// A pending write in M takes priority over W; x0 is never forwarded.
module forward_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_m_i,
    input  logic                  reg_write_w_i,
    output logic [1:0]            fwd_o
);
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush, post-reset flush, mul/div hold.
// Define HAZARD_PERF_CNT_EN to build the saturating StallCount/FlushCount registers; otherwise they read 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int CNT_W              = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] S_RST_FLUSH = RST_FLUSH;
    localparam logic [1:0] S_RUN       = RUN;
    localparam logic [1:0] S_MD_WAIT   = MD_WAIT;
    localparam logic [1:0] S_RESET     = (RESET_FLUSH_CYCLES == 0) ? S_RUN : S_RST_FLUSH;

    localparam int            RF_W    = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
    localparam logic [RF_W-1:0] RF_INIT = (RESET_FLUSH_CYCLES > 0) ? RF_W'(RESET_FLUSH_CYCLES - 1) : '0;

    logic [1:0]      state_q, state_d;
    logic [RF_W-1:0] rf_cnt_q, rf_cnt_d;
    logic [1:0]      fwd_a, fwd_b;
    logic            lw_stall, redirect, md_hold;
    logic            stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (hz.Rs1E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (hz.Rs2E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign lw_stall = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != '0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign redirect = (hz.PCSrcE != 2'b00);
    assign md_hold  = hz.MulDivStartE && !hz.MulDivDoneE;

    always_comb begin
        state_d  = state_q;
        rf_cnt_d = rf_cnt_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        case (state_q)
            S_RST_FLUSH: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
                if (rf_cnt_q == '0) state_d = S_RUN;
                else                rf_cnt_d = rf_cnt_q - RF_W'(1);
            end
            S_MD_WAIT: begin
                // Redirects are ignored here: the branch sits behind the held EX op.
                if (!hz.MulDivDoneE) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (md_hold) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    state_d = S_MD_WAIT;
                end else begin
                    stall_f = lw_stall && !redirect;
                    stall_d = lw_stall && !redirect;
                    flush_d = redirect;
                    flush_e = lw_stall || redirect;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            rf_cnt_q <= RF_INIT;
        end else begin
            state_q  <= state_d;
            rf_cnt_q <= rf_cnt_d;
        end
    end

    assign hz.ForwardAE = (state_q == S_RST_FLUSH) ? FWD_RF : fwd_a;
    assign hz.ForwardBE = (state_q == S_RST_FLUSH) ? FWD_RF : fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushM    = flush_m;

`ifdef HAZARD_PERF_CNT_EN
    logic             redirect_flush;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Only redirect flushes are counted, not the reset-flush sequence.
    assign redirect_flush = (state_q == S_RUN) && redirect && !md_hold;
    assign stall_cnt_d    = (stall_f && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d    = (redirect_flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;
`else
    assign hz.StallCount = '0;
    assign hz.FlushCount = '0;
`endif

endmodule
